// File: rtl/fadd_issue.sv
// fadd_issue: issue/retire stage around the combinational single-precision adder.
// Requests flow FIFO -> S1 (operand register) -> S2 (result register), in order.
// Optional macro FADD_ISSUE_FTZ_EN flushes subnormal operands and results to signed zero.
module fadd_issue #(
   parameter int DEPTH = 2,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_sub,
   input  logic [31:0]      req_x1,
   input  logic [31:0]      req_x2,
   input  logic [TAG_W-1:0] req_tag,
   output logic [31:0]      add_x1,
   output logic [31:0]      add_x2,
   output logic             add_ready,
   input  logic [31:0]      add_y,
   input  logic             add_valid,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [31:0]      res_y,
   output logic [TAG_W-1:0] res_tag
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = 64 + TAG_W;

   logic [EW-1:0]    mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             full;
   logic             empty;
   logic             push;
   logic             s1_load;
   logic             s2_load;
   logic             s1_valid;
   logic [TAG_W-1:0] s1_tag;
   logic [31:0]      in_x1;
   logic [31:0]      in_x2;
   logic [31:0]      y_cap;
   logic [EW-1:0]    head;

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty     = (wr_ptr == rd_ptr);
   assign req_ready = !full;
   assign push      = req_valid && !full;
   assign head      = mem[rd_ptr[AW-1:0]];
   assign add_ready = s1_valid && (!res_valid || res_ready);
   assign s2_load   = add_ready && add_valid;
   assign s1_load   = !empty && (!s1_valid || s2_load);

   // Decode subtract as a sign flip on x2 and optionally flush subnormals.
   always_comb begin
      in_x1 = req_x1;
      in_x2 = {req_sub ^ req_x2[31], req_x2[30:0]};
      y_cap = add_y;
`ifdef FADD_ISSUE_FTZ_EN
      if (in_x1[30:23] == 8'd0) in_x1 = {in_x1[31], 31'd0};
      if (in_x2[30:23] == 8'd0) in_x2 = {in_x2[31], 31'd0};
      if (y_cap[30:23] == 8'd0) y_cap = {y_cap[31], 31'd0};
`endif
   end

   // FIFO storage; contents are don't-care until written, so no reset needed.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= {in_x1, in_x2, req_tag};
   end

   // FIFO pointers advance on push and on transfer of the head into S1.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push)    wr_ptr <= wr_ptr + (AW+1)'(1);
         if (s1_load) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // S1 operand register holds steady until the core accepts it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_valid <= 1'b0;
         add_x1   <= '0;
         add_x2   <= '0;
         s1_tag   <= '0;
      end else if (s1_load) begin
         s1_valid <= 1'b1;
         add_x1   <= head[EW-1:EW-32];
         add_x2   <= head[EW-33:TAG_W];
         s1_tag   <= head[TAG_W-1:0];
      end else if (s2_load) begin
         s1_valid <= 1'b0;
      end
   end

   // S2 result register captures the core output and holds it under backpressure.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         res_valid <= 1'b0;
         res_y     <= '0;
         res_tag   <= '0;
      end else if (s2_load) begin
         res_valid <= 1'b1;
         res_y     <= y_cap;
         res_tag   <= s1_tag;
      end else if (res_ready) begin
         res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fadd_issue.sv
// tb_fadd_issue: directed self-checking bench for fadd_issue with a table-driven adder core model.
module tb_fadd_issue;

   localparam int DEPTH = 2;
   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             rstn;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic             req_sub = 1'b0;
   logic [31:0]      req_x1 = '0;
   logic [31:0]      req_x2 = '0;
   logic [TAG_W-1:0] req_tag = '0;
   logic [31:0]      add_x1;
   logic [31:0]      add_x2;
   logic             add_ready;
   logic [31:0]      add_y;
   logic             add_valid;
   logic             res_valid;
   logic             res_ready = 1'b0;
   logic [31:0]      res_y;
   logic [TAG_W-1:0] res_tag;
   logic             core_stall = 1'b0;

   int errors = 0;
   int checks = 0;
   int cycle  = 0;

   logic [31:0]      got_y   [$];
   logic [TAG_W-1:0] got_tag [$];
   int               got_cyc [$];

   fadd_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub),
      .req_x1(req_x1), .req_x2(req_x2), .req_tag(req_tag),
      .add_x1(add_x1), .add_x2(add_x2), .add_ready(add_ready),
      .add_y(add_y), .add_valid(add_valid),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_y(res_y), .res_tag(res_tag)
   );

   // Free-running clock and cycle counter.
   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   // Adder core stand-in: known float sums by table, plain integer add otherwise.
   function automatic logic [31:0] core_model(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         {32'h3F800000, 32'h40000000}: return 32'h40400000;
         {32'h40400000, 32'hBF800000}: return 32'h40000000;
         {32'h3F800000, 32'hBF800000}: return 32'h00000000;
         default:                      return a + b;
      endcase
   endfunction

   always_comb begin
      add_y     = core_model(add_x1, add_x2);
      add_valid = add_ready && !core_stall;
   end

   // Record every result handshake that will complete at the coming edge.
   always @(negedge clk) begin
      if (rstn === 1'b1 && res_valid && res_ready) begin
         got_y.push_back(res_y);
         got_tag.push_back(res_tag);
         got_cyc.push_back(cycle);
      end
   end

   task automatic clear_results();
      got_y.delete();
      got_tag.delete();
      got_cyc.delete();
   endtask

   // Offer one request starting at posedge+1; returns at posedge+1 after acceptance.
   task automatic send(input logic sub, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag);
      bit acc;
      acc       = 1'b0;
      req_valid = 1'b1;
      req_sub   = sub;
      req_x1    = a;
      req_x2    = b;
      req_tag   = tag;
      for (int i = 0; i < 50 && !acc; i++) begin
         acc = req_ready;
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      checks++;
      if (acc !== 1'b1) begin
         errors++;
         $display("[TB] FAIL send_accept tag=%0d: accepted=%0b required=1", tag, acc);
      end
   endtask

   task automatic wait_results(input int n);
      for (int i = 0; i < 100 && got_y.size() < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      #7;
      checks += 7;
      if (req_ready !== 1'b1)  begin errors++; $display("[TB] FAIL reset_req_ready: got %b required 1", req_ready); end
      if (add_ready !== 1'b0)  begin errors++; $display("[TB] FAIL reset_add_ready: got %b required 0", add_ready); end
      if (res_valid !== 1'b0)  begin errors++; $display("[TB] FAIL reset_res_valid: got %b required 0", res_valid); end
      if (add_x1 !== 32'h0)    begin errors++; $display("[TB] FAIL reset_add_x1: got %h required 0", add_x1); end
      if (add_x2 !== 32'h0)    begin errors++; $display("[TB] FAIL reset_add_x2: got %h required 0", add_x2); end
      if (res_y !== 32'h0)     begin errors++; $display("[TB] FAIL reset_res_y: got %h required 0", res_y); end
      if (res_tag !== 4'h0)    begin errors++; $display("[TB] FAIL reset_res_tag: got %h required 0", res_tag); end
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_single_add();
      clear_results();
      res_ready = 1'b1;
      req_valid = 1'b1;
      req_sub   = 1'b0;
      req_x1    = 32'h3F800000;
      req_x2    = 32'h40000000;
      req_tag   = 4'd3;
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_req_ready: got %b required 1", req_ready); end
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_lat_t1: res_valid got %b required 0", res_valid); end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_lat_t2: res_valid got %b required 0", res_valid); end
      @(posedge clk);
      @(negedge clk);
      checks += 3;
      if (res_valid !== 1'b1)     begin errors++; $display("[TB] FAIL single_lat_t3: res_valid got %b required 1", res_valid); end
      if (res_y !== 32'h40400000) begin errors++; $display("[TB] FAIL single_y: got %h required 40400000", res_y); end
      if (res_tag !== 4'd3)       begin errors++; $display("[TB] FAIL single_tag: got %0d required 3", res_tag); end
      @(posedge clk); #1;
      @(posedge clk); #1;
   endtask

   task automatic test_subtract();
      clear_results();
      res_ready = 1'b1;
      send(1'b1, 32'h40400000, 32'h3F800000, 4'd1);
      send(1'b1, 32'h3F800000, 32'h3F800000, 4'd2);
      wait_results(2);
      checks += 3;
      if (got_y.size() != 2) begin errors++; $display("[TB] FAIL sub_count: got %0d required 2", got_y.size()); end
      if ((got_y.size() > 0 ? got_y[0] : 32'hx) !== 32'h40000000)
         begin errors++; $display("[TB] FAIL sub_3m1: got %h required 40000000", got_y.size() > 0 ? got_y[0] : 32'hx); end
      if ((got_y.size() > 1 ? got_y[1] : 32'hx) !== 32'h00000000)
         begin errors++; $display("[TB] FAIL sub_1m1: got %h required 00000000", got_y.size() > 1 ? got_y[1] : 32'hx); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ey;
      clear_results();
      res_ready = 1'b1;
      for (int i = 0; i < 8; i++) send(1'b0, 32'h01000000 + i, 32'h01000000, TAG_W'(i));
      wait_results(8);
      checks++;
      if (got_y.size() != 8) begin errors++; $display("[TB] FAIL b2b_count: got %0d required 8", got_y.size()); end
      for (int i = 0; i < 8; i++) begin
         ey = 32'h02000000 + i;
         checks += 3;
         if ((got_tag.size() > i ? got_tag[i] : 4'hx) !== TAG_W'(i))
            begin errors++; $display("[TB] FAIL b2b_tag%0d: got %h required %0d", i, got_tag.size() > i ? got_tag[i] : 4'hx, i); end
         if ((got_y.size() > i ? got_y[i] : 32'hx) !== ey)
            begin errors++; $display("[TB] FAIL b2b_y%0d: got %h required %h", i, got_y.size() > i ? got_y[i] : 32'hx, ey); end
         if (got_cyc.size() > i && (got_cyc[i] - got_cyc[0]) != i)
            begin errors++; $display("[TB] FAIL b2b_cycle%0d: offset %0d required %0d", i, got_cyc[i] - got_cyc[0], i); end
      end
   endtask

   task automatic test_stall();
      clear_results();
      res_ready  = 1'b1;
      core_stall = 1'b1;
      send(1'b0, 32'h3F800000, 32'h40000000, 4'd5);
      for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
      checks += 4;
      if (add_ready !== 1'b1)      begin errors++; $display("[TB] FAIL stall_add_ready: got %b required 1", add_ready); end
      if (add_x1 !== 32'h3F800000) begin errors++; $display("[TB] FAIL stall_x1: got %h required 3f800000", add_x1); end
      if (add_x2 !== 32'h40000000) begin errors++; $display("[TB] FAIL stall_x2: got %h required 40000000", add_x2); end
      if (res_valid !== 1'b0)      begin errors++; $display("[TB] FAIL stall_res_valid: got %b required 0", res_valid); end
      core_stall = 1'b0;
      wait_results(1);
      checks += 2;
      if ((got_y.size() > 0 ? got_y[0] : 32'hx) !== 32'h40400000)
         begin errors++; $display("[TB] FAIL stall_y: got %h required 40400000", got_y.size() > 0 ? got_y[0] : 32'hx); end
      if ((got_tag.size() > 0 ? got_tag[0] : 4'hx) !== 4'd5)
         begin errors++; $display("[TB] FAIL stall_tag: got %h required 5", got_tag.size() > 0 ? got_tag[0] : 4'hx); end
   endtask

   task automatic test_backpressure();
      int pushed;
      clear_results();
      res_ready = 1'b0;
      pushed    = 0;
      req_sub   = 1'b0;
      req_x1    = 32'h01000000;
      req_x2    = 32'h01000000;
      for (int c = 0; c < 12; c++) begin
         req_valid = (pushed < 5);
         req_tag   = TAG_W'(pushed);
         if (req_valid && req_ready) pushed++;
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      checks += 4;
      if (pushed != 4)        begin errors++; $display("[TB] FAIL bp_accepted: got %0d required 4", pushed); end
      if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_req_ready_full: got %b required 0", req_ready); end
      if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_res_valid: got %b required 1", res_valid); end
      if (res_tag !== 4'd0)   begin errors++; $display("[TB] FAIL bp_hold_tag: got %0d required 0", res_tag); end
      res_ready = 1'b1;
      wait_results(4);
      @(posedge clk); #1;
      checks++;
      if (got_tag.size() != 4) begin errors++; $display("[TB] FAIL bp_count: got %0d required 4", got_tag.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ((got_tag.size() > i ? got_tag[i] : 4'hx) !== TAG_W'(i))
            begin errors++; $display("[TB] FAIL bp_tag%0d: got %h required %0d", i, got_tag.size() > i ? got_tag[i] : 4'hx, i); end
      end
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_req_ready_drain: got %b required 1", req_ready); end
   endtask

   task automatic test_subnormal();
      logic [31:0] ey;
`ifdef FADD_ISSUE_FTZ_EN
      ey = 32'h00000000;
`else
      ey = 32'h00800000;
`endif
      clear_results();
      res_ready = 1'b1;
      send(1'b0, 32'h00400000, 32'h00400000, 4'd9);
      wait_results(1);
      checks += 2;
      if ((got_y.size() > 0 ? got_y[0] : 32'hx) !== ey)
         begin errors++; $display("[TB] FAIL subnormal_y: got %h required %h", got_y.size() > 0 ? got_y[0] : 32'hx, ey); end
      if ((got_tag.size() > 0 ? got_tag[0] : 4'hx) !== 4'd9)
         begin errors++; $display("[TB] FAIL subnormal_tag: got %h required 9", got_tag.size() > 0 ? got_tag[0] : 4'hx); end
   endtask

   task automatic test_reset_midflight();
      clear_results();
      res_ready = 1'b0;
      send(1'b0, 32'h01000000, 32'h01000000, 4'd1);
      send(1'b0, 32'h01000000, 32'h01000000, 4'd2);
      send(1'b0, 32'h01000000, 32'h01000000, 4'd3);
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre_res_valid: got %b required 1", res_valid); end
      rstn = 1'b0;
      #1;
      checks += 3;
      if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_res_valid: got %b required 0", res_valid); end
      if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_req_ready: got %b required 1", req_ready); end
      if (add_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_add_ready: got %b required 0", add_ready); end
      @(posedge clk); #1;
      rstn      = 1'b1;
      res_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
      checks++;
      if (got_y.size() != 0) begin errors++; $display("[TB] FAIL mid_stale: got %0d results required 0", got_y.size()); end
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_single_add();
      test_subtract();
      test_back_to_back();
      test_stall();
      test_backpressure();
      test_subnormal();
      test_reset_midflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fadd_issue.md
# fadd_issue

Issue/retire stage wrapped around the combinational single-precision adder core (`fadd`). Requests are buffered in a small in-order FIFO, decoded as add or subtract, and registered onto the adder's operand inputs. The adder's result is captured into an output register behind a valid/ready handshake, so the core's combinational path sits between two register stages and the FPU dispatcher sees a fully pipelined, back-pressurable unit.

## Interface
Parameters:
- `DEPTH`, 2: request FIFO entries; power of two, ≥2.
- `TAG_W`, 4: width of the opaque tag carried alongside each request.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  FIFO can accept; equals `!fifo_full`, registered state only.
- `req_sub`  in  1  0 = x1+x2, 1 = x1−x2.
- `req_x1`, `req_x2`  in  32  IEEE-754 single operands.
- `req_tag`  in  TAG_W  returned unchanged with the result.
- `add_x1`, `add_x2`  out  32  operands to the adder core (from S1 register).
- `add_ready`  out  1  issue strobe to the core.
- `add_y`  in  32  core result.
- `add_valid`  in  1  core result valid in the same cycle.
- `res_valid`  out  1  result register holds data.
- `res_ready`  in  1  consumer accepts.
- `res_y`  out  32  sum.
- `res_tag`  out  TAG_W  tag of that sum.

## Operation
- Three storage elements in order: FIFO → S1 (operand register + tag) → S2 (result register + tag). Strictly in order; no reordering, no bypass.
- Push: `req_valid && req_ready`. Entry = {x1, x2′, tag}, where x2′ = `{req_sub ^ x2[31], x2[30:0]}`. Sign flip applies to NaN/Inf/zero as well; no other decoding.
- S1 loads FIFO head when FIFO non-empty and (S1 empty or S1 advancing).
- `add_ready = s1_valid && (!s2_valid || res_ready)`.
- S1 advances into S2 when `add_ready && add_valid`; S2 captures `add_y` and S1's tag. If `add_ready && !add_valid`, S1 holds, operands stable.
- S2 clears on `res_valid && res_ready` unless reloaded the same cycle.
- FIFO full: `req_ready` = 0 even if a pop happens that cycle. FIFO empty with push: entry goes through FIFO (no direct load to S1).
- Pointers are log2(DEPTH)+1 bits; wrap-around via MSB compare.

## Timing
- Reset (asynchronous assert, outputs valid immediately): `req_ready` 1, `add_ready` 0, `res_valid` 0, `add_x1`/`add_x2`/`res_y` 0, `res_tag` 0, FIFO empty. Reset mid-operation discards all in-flight requests; nothing is emitted after release.
- Latency, with no stalls and the core returning `add_valid = add_ready`: accepted at edge t → S1 at edge t+1 → S2 at edge t+2 → `res_valid` high in cycle t+3.
- Throughput: one result per cycle when `res_ready` is held high.
- With `res_ready` low: S2 holds, then S1 holds, then the FIFO fills. `req_ready` falls in the cycle after the DEPTH-th buffered entry. Capacity = DEPTH+2 requests.
- `res_y`/`res_tag` stable while `res_valid && !res_ready`.

## Configuration
- `FADD_ISSUE_FTZ_EN` defined: at push, any operand with exponent 0 has its mantissa cleared (sign kept). On the result side, an `add_y` with exponent 0 is captured as `{sign, 31'b0}`. Adds no latency.
- Undefined: operands and result pass unchanged; subnormals are handled by the core.

## Test plan
- Single add: x1=0x3F800000, x2=0x40000000, sub=0, tag=3 → `res_valid` in cycle t+3, `res_y`=0x40400000, `res_tag`=3.
- Subtract: x1=0x40400000, x2=0x3F800000, sub=1 → 0x40000000. Also x1=x2=0x3F800000, sub=1 → 0x00000000.
- Back-to-back stream: 8 requests with tags 0..7, `res_ready`=1 → 8 results on consecutive cycles, tags in order 0..7.
- Backpressure: DEPTH=2, `res_ready`=0, push 5 → exactly 4 accepted and `req_ready`=0. Release `res_ready` → 4 results in order, then `req_ready`=1.
- Subnormal: x1=x2=0x00400000, add → 0x00800000 without the macro; 0x00000000 with `FADD_ISSUE_FTZ_EN`.
- Reset mid-flight: 3 requests queued, pulse `rstn` low for one cycle → `res_valid` 0 and `req_ready` 1 immediately; no stale results after release.
